// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller issuing one registered bus access per load/store, with timeout and lane handling.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] pc_i,
  input  logic [1:0]  type_i,
  input  logic        dramwe_i,
  input  logic        mem_rd_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        unsigned_i,
  input  logic [4:0]  regwr_i,
  input  logic        regwe_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_o,
  output logic        wb_valid,
  output logic        wb_regwe,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_regwr,
  output logic [31:0] wb_data,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] l_type, l_off;
  logic l_uns, l_regwe, l_we;
  logic is_mem, mis, accept, tmo;
  logic [3:0] be;
  logic [31:0] wd, sh, ld;
  always_comb begin
    is_mem = dramwe_i | mem_rd_i;
    mis = (type_i == 2'b01 && addr_i[0]) || (type_i[1] && addr_i[1:0] != 2'b00);
    accept = state == IDLE && ex_valid && is_mem && !mis;
    tmo = state == BUSY && !bus_ack && cnt == CW'(TIMEOUT - 1);
    state_n = accept ? BUSY : (state == BUSY && (bus_ack || tmo)) ? IDLE : state;
    stall_o = rst_n && (accept || (state == BUSY && !bus_ack && !tmo));
    be = type_i == 2'b00 ? 4'b0001 << addr_i[1:0] : type_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = type_i == 2'b00 ? {4{wdata_i[7:0]}} : type_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    sh = bus_rdata >> {l_off, 3'b000};
    ld = l_type == 2'b00 ? {{24{sh[7] & !l_uns}}, sh[7:0]} :
         l_type == 2'b01 ? {{16{sh[15] & !l_uns}}, sh[15:0]} : bus_rdata;
  end
  // Access attributes are latched at accept so completion does not depend on upstream holding its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      {l_type, l_off, l_uns, l_regwe, l_we} <= '0;
      {bus_req, bus_we, bus_addr, bus_be, bus_wdata} <= '0;
      {wb_valid, wb_regwe, wb_pc, wb_regwr, wb_data} <= '0;
      {misalign_o, bus_err_o} <= '0;
    end else begin
      state <= state_n;
      wb_valid <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid) begin
          wb_pc <= pc_i;
          wb_regwr <= regwr_i;
          if (!is_mem || mis) begin
            wb_valid <= 1'b1;
            wb_regwe <= !is_mem && regwe_i;
            wb_data <= addr_i;
            misalign_o <= is_mem;
          end else begin
            bus_req <= 1'b1;
            bus_we <= dramwe_i;
            bus_addr <= {addr_i[31:2], 2'b00};
            bus_be <= be;
            bus_wdata <= wd;
            cnt <= '0;
            {l_type, l_off, l_uns, l_regwe, l_we} <= {type_i, addr_i[1:0], unsigned_i, regwe_i, dramwe_i};
          end
        end
      end else if (bus_ack) begin
        bus_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_regwe <= l_regwe && !l_we;
        wb_data <= ld;
      end else if (tmo) begin
        bus_req <= 1'b0;
        bus_err_o <= 1'b1;
        wb_valid <= 1'b1;
        wb_regwe <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed bench with a per-transaction timeline model and a per-cycle output comparator.
module tb_mem_stage_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n;
  logic ex_valid, dramwe_i, mem_rd_i, unsigned_i, regwe_i, bus_ack;
  logic [1:0] type_i;
  logic [4:0] regwr_i;
  logic [31:0] pc_i, addr_i, wdata_i, bus_rdata;
  logic bus_req, bus_we, stall_o, wb_valid, wb_regwe, misalign_o, bus_err_o;
  logic [3:0] bus_be;
  logic [4:0] wb_regwr;
  logic [31:0] bus_addr, bus_wdata, wb_pc, wb_data;
  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_i(pc_i), .type_i(type_i),
    .dramwe_i(dramwe_i), .mem_rd_i(mem_rd_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .unsigned_i(unsigned_i), .regwr_i(regwr_i), .regwe_i(regwe_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_o(stall_o),
    .wb_valid(wb_valid), .wb_regwe(wb_regwe), .wb_pc(wb_pc), .wb_regwr(wb_regwr),
    .wb_data(wb_data), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, acc_cyc = 0, wb_cyc = 0;
  int stall_cnt = 0, req_cnt = 0, mis_cnt = 0, err_cnt = 0;
  logic [31:0] last_data, last_bus_addr;
  logic last_wbwe;
  logic chk_en = 1'b0, chk_bus, chk_data;
  logic e_stall, e_req, e_we, e_mis, e_err, e_wbv, e_wbwe;
  logic [3:0] e_be;
  logic [4:0] e_regwr;
  logic [31:0] e_addr, e_wdata, e_pc, e_data;
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic m_mis(input logic [1:0] ty, input logic [31:0] a);
    return (ty == 2'd1 && a % 2 != 0) || (ty >= 2'd2 && a % 4 != 0);
  endfunction
  function automatic logic [3:0] m_be(input logic [1:0] ty, input logic [31:0] a);
    int off = int'(a % 4);
    return ty == 2'd0 ? 4'(1 << off) : ty == 2'd1 ? (off >= 2 ? 4'hC : 4'h3) : 4'hF;
  endfunction
  function automatic logic [31:0] m_wd(input logic [1:0] ty, input logic [31:0] wd);
    return ty == 2'd0 ? (wd & 32'hFF) * 32'h01010101 : ty == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
  endfunction
  function automatic logic [31:0] m_ld(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] rd, input logic un);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (ty == 2'd0) begin
      v = v & 32'hFF;
      if (!un && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (ty == 2'd1) begin
      v = v & 32'hFFFF;
      if (!un && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) if (chk_en) begin
    ck("stall_o", 32'(stall_o), 32'(e_stall));
    ck("bus_req", 32'(bus_req), 32'(e_req));
    ck("misalign_o", 32'(misalign_o), 32'(e_mis));
    ck("bus_err_o", 32'(bus_err_o), 32'(e_err));
    ck("wb_valid", 32'(wb_valid), 32'(e_wbv));
    if (chk_bus) begin
      ck("bus_we", 32'(bus_we), 32'(e_we));
      ck("bus_addr", bus_addr, e_addr);
      ck("bus_be", 32'(bus_be), 32'(e_be));
      ck("bus_wdata", bus_wdata, e_wdata);
    end
    if (e_wbv) begin
      ck("wb_regwe", 32'(wb_regwe), 32'(e_wbwe));
      ck("wb_pc", wb_pc, e_pc);
      ck("wb_regwr", 32'(wb_regwr), 32'(e_regwr));
      if (chk_data) ck("wb_data", wb_data, e_data);
    end
    if (stall_o) stall_cnt++;
    if (bus_req) begin
      req_cnt++;
      last_bus_addr = bus_addr;
    end
    if (misalign_o) mis_cnt++;
    if (bus_err_o) err_cnt++;
    if (wb_valid) begin
      last_data = wb_data;
      last_wbwe = wb_regwe;
      wb_cyc = cyc_n;
    end
  end
  task automatic clr();
    {e_stall, e_req, e_we, e_mis, e_err, e_wbv, e_wbwe, chk_bus, chk_data} = '0;
    {e_be, e_regwr, e_addr, e_wdata, e_pc, e_data} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int s0, r0, m0, b0;
  // w = no-ack BUSY cycles before the ack cycle; w < 0 means the ack never comes.
  task automatic run_op(input logic st, input logic ldr, input logic [1:0] ty, input logic [31:0] a,
                        input logic [31:0] wd, input logic un, input logic rwe, input logic [31:0] rd,
                        input int w, input logic [31:0] pc, input logic [4:0] rg);
    logic mem, misal, timed, ack;
    int last;
    mem = st | ldr;
    misal = mem && m_mis(ty, a);
    timed = w < 0 || w >= TO;
    last = timed ? TO : w + 1;
    s0 = stall_cnt; r0 = req_cnt; m0 = mis_cnt; b0 = err_cnt;
    step();
    {ex_valid, dramwe_i, mem_rd_i, type_i, addr_i, wdata_i, unsigned_i, regwe_i, pc_i, regwr_i} =
      {1'b1, st, ldr, ty, a, wd, un, rwe, pc, rg};
    bus_ack = 1'b0;
    acc_cyc = cyc_n;
    clr();
    e_stall = mem && !misal;
    if (!mem || misal) begin
      step();
      ex_valid = 1'b0;
      clr();
      {e_wbv, e_pc, e_regwr, e_mis, e_wbwe, e_data, chk_data} = {1'b1, pc, rg, misal, !misal && rwe, a, !misal};
    end else begin
      for (int k = 1; k <= last; k++) begin
        step();
        clr();
        ack = !timed && k == w + 1;
        bus_ack = ack;
        bus_rdata = ack ? rd : 32'hDEADBEEF;
        {chk_bus, e_req, e_we, e_addr, e_be, e_wdata} = {1'b1, 1'b1, st, a & ~32'h3, m_be(ty, a), m_wd(ty, wd)};
        e_stall = !ack && k < TO;
      end
      step();
      {ex_valid, bus_ack} = 2'b00;
      clr();
      {e_wbv, e_pc, e_regwr, e_err} = {1'b1, pc, rg, timed};
      e_wbwe = !timed && !st && rwe;
      chk_data = !timed && !st;
      e_data = m_ld(ty, a, rd, un);
    end
    step();
    clr();
  endtask
  initial begin
    rst_n = 1'b0;
    {ex_valid, dramwe_i, mem_rd_i, type_i, addr_i, wdata_i, unsigned_i, regwe_i, pc_i, regwr_i} = '0;
    {bus_ack, bus_rdata} = '0;
    clr();
    ex_valid = 1'b1; mem_rd_i = 1'b1; type_i = 2'd2;
    repeat (2) @(posedge clk);
    #2;
    ck("rst_stall", 32'(stall_o), 0);
    ck("rst_req", 32'(bus_req), 0);
    ck("rst_wbv", 32'(wb_valid), 0);
    ck("rst_pulses", 32'({misalign_o, bus_err_o}), 0);
    ex_valid = 1'b0; mem_rd_i = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    // ALU op: misaligned-looking address is irrelevant without a memory access
    run_op(0, 0, 2'd2, 32'h12345677, 0, 0, 1, 0, 0, 32'h1000, 5'd3);
    ck("alu_data", last_data, 32'h12345677);
    ck("alu_regwe", 32'(last_wbwe), 1);
    // SB
    run_op(1, 0, 2'd0, 32'h103, 32'hAB, 0, 1, 0, 2, 32'h1004, 5'd4);
    ck("sb_addr", last_bus_addr, 32'h100);
    ck("sb_be_model", 32'(m_be(2'd0, 32'h103)), 32'h8);
    ck("sb_wd_model", m_wd(2'd0, 32'hAB), 32'hABABABAB);
    ck("sb_stall_cycles", 32'(stall_cnt - s0), 3);
    ck("sb_regwe", 32'(last_wbwe), 0);
    // LH signed, zero-wait
    run_op(0, 1, 2'd1, 32'h202, 0, 0, 1, 32'h80011234, 0, 32'h1008, 5'd5);
    ck("lh_data", last_data, 32'hFFFF8001);
    ck("lh_latency", 32'(wb_cyc - acc_cyc), 2);
    // LBU
    run_op(0, 1, 2'd0, 32'h201, 0, 1, 1, 32'h0000F000, 1, 32'h100C, 5'd6);
    ck("lbu_data", last_data, 32'h000000F0);
    // LW misaligned
    run_op(0, 1, 2'd2, 32'h102, 0, 0, 1, 0, 0, 32'h1010, 5'd7);
    ck("mis_req", 32'(req_cnt - r0), 0);
    ck("mis_pulse", 32'(mis_cnt - m0), 1);
    ck("mis_stall", 32'(stall_cnt - s0), 0);
    ck("mis_regwe", 32'(last_wbwe), 0);
    // LW timeout
    run_op(0, 1, 2'd2, 32'h400, 0, 0, 1, 0, -1, 32'h1014, 5'd8);
    ck("to_err", 32'(err_cnt - b0), 1);
    ck("to_req_cycles", 32'(req_cnt - r0), 16);
    ck("to_stall_cycles", 32'(stall_cnt - s0), 16);
    // more lane patterns
    run_op(0, 1, 2'd3, 32'h504, 0, 0, 1, 32'hCAFEF00D, 3, 32'h1018, 5'd9);
    ck("lw11_data", last_data, 32'hCAFEF00D);
    run_op(1, 0, 2'd1, 32'h506, 32'h1234BEEF, 0, 1, 0, 1, 32'h101C, 5'd10);
    run_op(0, 1, 2'd0, 32'h603, 0, 0, 1, 32'h80FFFFFF, 15, 32'h1020, 5'd11);
    ck("lb_data", last_data, 32'hFFFFFF80);
    run_op(0, 1, 2'd1, 32'h700, 0, 1, 1, 32'h1234FFFE, 0, 32'h1024, 5'd12);
    ck("lhu_data", last_data, 32'h0000FFFE);
    run_op(0, 1, 2'd1, 32'h701, 0, 0, 1, 0, 0, 32'h1028, 5'd13);
    run_op(1, 1, 2'd2, 32'h800, 32'h55AA55AA, 0, 1, 0, 0, 32'h102C, 5'd14);
    ck("st_wins_regwe", 32'(last_wbwe), 0);
    // ack while idle is ignored
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    // reset in the middle of BUSY with the instruction still presented
    step();
    {ex_valid, dramwe_i, mem_rd_i, type_i, addr_i} = {1'b1, 1'b0, 1'b1, 2'd2, 32'h900};
    clr();
    e_stall = 1'b1;
    repeat (2) begin
      step();
      clr();
      {e_req, e_stall} = 2'b11;
    end
    #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    ck("midrst_req", 32'(bus_req), 0);
    ck("midrst_stall", 32'(stall_o), 0);
    ck("midrst_wbv", 32'(wb_valid), 0);
    @(negedge clk);
    #2;
    ex_valid = 1'b0;
    bus_ack = 1'b1;
    rst_n = 1'b1;
    clr();
    chk_en = 1'b1;
    run_op(0, 1, 2'd0, 32'h202, 0, 1, 1, 32'h00440000, 0, 32'h1030, 5'd15);
    ck("post_rst_data", last_data, 32'h44);
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
